// File: rtl/frac_lutk_ccff.sv
// K-input fracturable LUT whose truth table, fracture mode and output-register enable
// are loaded serially through a configuration flip-flop chain (ccff_head -> ccff_tail).
module frac_lutk_ccff #(
   parameter int K = 4,
   localparam int TT_BITS = 2**K,
   localparam int CHAIN_LEN = TT_BITS + 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         cfg_en,
   input  logic         cfg_restart,
   input  logic         ccff_head,
   output logic         ccff_tail,
   output logic         cfg_done,
   input  logic [K-1:0] in,
   output logic         lutk_out,
   output logic [1:0]   lutk1_out
);

   localparam int CNT_W = $clog2(CHAIN_LEN + 1);

   logic [CHAIN_LEN-1:0] cfg;
   logic [CNT_W-1:0]     bit_cnt;

   logic [TT_BITS-1:0]   tt;
   logic                 mode;
   logic                 reg_en;
   logic [K-1:0]         idx;
   logic [K-2:0]         lo;
   logic                 f0;
   logic                 f1;
   logic                 active;
   logic                 lutk_c;
   logic [1:0]           lutk1_c;
   logic                 lutk_q;
   logic [1:0]           lutk1_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cfg <= '0;
      end else if (cfg_en) begin
         cfg <= {cfg[CHAIN_LEN-2:0], ccff_head};
      end
   end

   // Restart wins over counting; the shift itself is unaffected by restart.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bit_cnt <= '0;
      end else if (cfg_restart) begin
         bit_cnt <= '0;
      end else if (cfg_en && (bit_cnt != CNT_W'(CHAIN_LEN))) begin
         bit_cnt <= bit_cnt + 1'b1;
      end
   end

   assign cfg_done  = (bit_cnt == CNT_W'(CHAIN_LEN));
   assign ccff_tail = cfg[CHAIN_LEN-1];

   assign tt     = cfg[TT_BITS-1:0];
   assign mode   = cfg[TT_BITS];
   assign reg_en = cfg[TT_BITS+1];

   assign lo  = in[K-2:0];
   assign idx = {in[K-1] | mode, lo};
   assign f0  = tt[{1'b0, lo}];
   assign f1  = tt[{1'b1, lo}];

   // Results are only meaningful with a complete, stable configuration.
   assign active  = cfg_done & ~cfg_en;
   assign lutk_c  = active & tt[idx];
   assign lutk1_c = active ? {f0, f1} : 2'b00;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lutk_q  <= 1'b0;
         lutk1_q <= 2'b00;
      end else begin
         lutk_q  <= lutk_c;
         lutk1_q <= lutk1_c;
      end
   end

   assign lutk_out  = reg_en ? lutk_q  : lutk_c;
   assign lutk1_out = reg_en ? lutk1_q : lutk1_c;

endmodule
